// File: rtl/cmp_result_tracker_pkg.sv
// cmp_result_tracker_pkg
//   Shared definitions for the 2-bit magnitude comparator result path:
//   class/state codes and the one-hot legality check on the F1..F3 flags.
//   No ports.
package cmp_result_tracker_pkg;

  localparam logic [1:0] CMP_NONE = 2'b00;
  localparam logic [1:0] CMP_EQ   = 2'b01;
  localparam logic [1:0] CMP_LT   = 2'b10;
  localparam logic [1:0] CMP_GT   = 2'b11;

  // Run-tracking state; the encoding doubles as the TREND output code.
  typedef enum logic [1:0] {
    S_IDLE = CMP_NONE,
    S_EQ   = CMP_EQ,
    S_LT   = CMP_LT,
    S_GT   = CMP_GT
  } state_t;

  // flags = {F3, F2, F1}
  function automatic logic is_one_hot3(input logic [2:0] flags);
    return (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
  endfunction

  // Class of a legal sample; S_IDLE for anything that is not one-hot.
  function automatic state_t class_of(input logic [2:0] flags);
    case (flags)
      3'b001:  return S_EQ;
      3'b010:  return S_LT;
      3'b100:  return S_GT;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cmp_result_tracker_sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear and load-to-one.
//   Priority: clr > load1 > inc. Holds at all-ones instead of wrapping.
// Ports
//   clk    in   1  rising-edge clock
//   clr    in   1  synchronous clear to 0
//   load1  in   1  load the value 1 (start of a new run)
//   inc    in   1  increment, saturating
//   q      out  W  current count
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load1) begin
      q <= W'(1);
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/cmp_result_tracker.sv
// cmp_result_tracker
//   Samples the comparator one-hot flags F1 (EQ), F2 (LT), F3 (GT) when VALID
//   is high. Keeps saturating per-class tallies, tracks the current run class
//   and length, and flags non-one-hot samples with a sticky ERR.
//   Optional feature macro: CMP_STREAK_ALARM_EN (ALARM when STREAK >= STREAK_TH);
//   without it ALARM is tied low. Port list is the same in both builds.
// Ports
//   CLK     in   1       rising-edge clock
//   RST     in   1       synchronous active-high reset
//   CLR     in   1       synchronous soft clear (same effect as RST)
//   VALID   in   1       F1..F3 carry a sample this cycle
//   F1..F3  in   1       comparator EQ / LT / GT flags
//   EQ_CNT  out  CNT_W   accepted EQ samples (saturating)
//   LT_CNT  out  CNT_W   accepted LT samples (saturating)
//   GT_CNT  out  CNT_W   accepted GT samples (saturating)
//   TREND   out  2       current run class (state code)
//   STREAK  out  STRK_W  current run length (saturating)
//   ERR     out  1       sticky illegal-flags indicator
//   ALARM   out  1       STREAK >= STREAK_TH (feature build only)
//
// state  | meaning
// S_IDLE | no legal sample since reset/clear
// S_EQ   | current run is AB = CD
// S_LT   | current run is AB < CD
// S_GT   | current run is AB > CD
module cmp_result_tracker
  import cmp_result_tracker_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int STRK_W    = 4,
  parameter int STREAK_TH = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              VALID,
  input  logic              F1,
  input  logic              F2,
  input  logic              F3,
  output logic [CNT_W-1:0]  EQ_CNT,
  output logic [CNT_W-1:0]  LT_CNT,
  output logic [CNT_W-1:0]  GT_CNT,
  output logic [1:0]        TREND,
  output logic [STRK_W-1:0] STREAK,
  output logic              ERR,
  output logic              ALARM
);

  logic [2:0] flags;
  logic       clr_any;
  logic       legal;
  logic       illegal;
  logic       same_run;
  state_t     state;
  state_t     sample_class;

  assign flags        = {F3, F2, F1};
  assign clr_any      = RST | CLR;
  assign legal        = VALID & is_one_hot3(flags);
  assign illegal      = VALID & ~is_one_hot3(flags);
  assign sample_class = class_of(flags);
  // From S_IDLE every legal sample starts a run; class_of never yields S_IDLE
  // for a legal sample, so the equality alone covers that case.
  assign same_run     = legal && (sample_class == state);

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk(CLK), .clr(clr_any), .load1(1'b0), .inc(legal & F1), .q(EQ_CNT)
  );

  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk(CLK), .clr(clr_any), .load1(1'b0), .inc(legal & F2), .q(LT_CNT)
  );

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk(CLK), .clr(clr_any), .load1(1'b0), .inc(legal & F3), .q(GT_CNT)
  );

  sat_counter #(.W(STRK_W)) u_streak (
    .clk(CLK), .clr(clr_any), .load1(legal & ~same_run), .inc(same_run), .q(STREAK)
  );

  always_ff @(posedge CLK) begin
    if (clr_any) begin
      state <= S_IDLE;
      ERR   <= 1'b0;
    end else begin
      if (illegal) begin
        ERR <= 1'b1;
      end
      if (legal) begin
        state <= sample_class;
      end
    end
  end

  assign TREND = state;

`ifdef CMP_STREAK_ALARM_EN
  localparam logic [STRK_W-1:0] STRK_MAX = '1;
  localparam logic [31:0]       TH       = STREAK_TH;

  logic [STRK_W-1:0] streak_nxt;

  // Mirror of what the streak counter will hold after this edge, so the
  // alarm lands in the same cycle as the STREAK update.
  always_comb begin
    streak_nxt = STREAK;
    if (same_run) begin
      if (STREAK != STRK_MAX) begin
        streak_nxt = STREAK + STRK_W'(1);
      end
    end else if (legal) begin
      streak_nxt = STRK_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (clr_any) begin
      ALARM <= 1'b0;
    end else if (legal) begin
      ALARM <= (32'(streak_nxt) >= TH);
    end
  end
`else
  logic unused_th;
  assign unused_th = |STREAK_TH;
  assign ALARM     = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_result_tracker.sv
module tb_cmp_result_tracker;

  logic CLK = 1'b0;
  logic RST, CLR, VALID, F1, F2, F3;

  logic [3:0] eq_cnt, lt_cnt, gt_cnt, streak;
  logic [1:0] trend;
  logic       err, alarm;

  logic [1:0] s_eq_cnt, s_lt_cnt, s_gt_cnt, s_streak;
  logic [1:0] s_trend;
  logic       s_err, s_alarm;

  int tests = 0;
  int fails = 0;

`ifdef CMP_STREAK_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  always #5 CLK = ~CLK;

  cmp_result_tracker #(.CNT_W(4), .STRK_W(4), .STREAK_TH(3)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .VALID(VALID), .F1(F1), .F2(F2), .F3(F3),
    .EQ_CNT(eq_cnt), .LT_CNT(lt_cnt), .GT_CNT(gt_cnt), .TREND(trend),
    .STREAK(streak), .ERR(err), .ALARM(alarm)
  );

  cmp_result_tracker #(.CNT_W(2), .STRK_W(2), .STREAK_TH(3)) dut_s (
    .CLK(CLK), .RST(RST), .CLR(CLR), .VALID(VALID), .F1(F1), .F2(F2), .F3(F3),
    .EQ_CNT(s_eq_cnt), .LT_CNT(s_lt_cnt), .GT_CNT(s_gt_cnt), .TREND(s_trend),
    .STREAK(s_streak), .ERR(s_err), .ALARM(s_alarm)
  );

  // Drive one VALID cycle with flags {f3,f2,f1}; returns 1 ns after the edge.
  task automatic do_sample(input logic [2:0] f, input logic with_clr = 1'b0);
    @(negedge CLK);
    VALID = 1'b1; F3 = f[2]; F2 = f[1]; F1 = f[0]; CLR = with_clr;
    @(posedge CLK);
    #1;
    VALID = 1'b0; F3 = 1'b0; F2 = 1'b0; F1 = 1'b0; CLR = 1'b0;
  endtask

  task automatic do_idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_clear();
    @(negedge CLK);
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1; VALID = 1'b1; F3 = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0; VALID = 1'b0; F3 = 1'b0;
    tests++;
    if ({eq_cnt, lt_cnt, gt_cnt} !== 12'h000) begin
      $display("FAIL reset_counts got %h want 000", {eq_cnt, lt_cnt, gt_cnt}); fails++;
    end
    tests++;
    if ({trend, streak} !== 6'd0) begin
      $display("FAIL reset_trend_streak got trend=%b streak=%0d want 00/0", trend, streak); fails++;
    end
    tests++;
    if ({err, alarm} !== 2'b00) begin
      $display("FAIL reset_err_alarm got err=%b alarm=%b want 0/0", err, alarm); fails++;
    end
    tests++;
    if ({s_eq_cnt, s_lt_cnt, s_gt_cnt, s_trend, s_streak, s_err, s_alarm} !== 12'h000) begin
      $display("FAIL reset_small got %h want 000",
               {s_eq_cnt, s_lt_cnt, s_gt_cnt, s_trend, s_streak, s_err, s_alarm}); fails++;
    end
  endtask

  task automatic test_run_tracking();
    do_sample(3'b100);
    tests++;
    if (trend !== 2'b11 || streak !== 4'd1 || gt_cnt !== 4'd1) begin
      $display("FAIL run_first_gt got trend=%b streak=%0d gt=%0d want 11/1/1", trend, streak, gt_cnt);
      fails++;
    end
    do_sample(3'b100);
    do_sample(3'b100);
    tests++;
    if (trend !== 2'b11 || streak !== 4'd3 || gt_cnt !== 4'd3) begin
      $display("FAIL run_three_gt got trend=%b streak=%0d gt=%0d want 11/3/3", trend, streak, gt_cnt);
      fails++;
    end
    do_sample(3'b010);
    tests++;
    if ({gt_cnt, lt_cnt, eq_cnt} !== {4'd3, 4'd1, 4'd0}) begin
      $display("FAIL run_counts got gt=%0d lt=%0d eq=%0d want 3/1/0", gt_cnt, lt_cnt, eq_cnt); fails++;
    end
    tests++;
    if (trend !== 2'b10 || streak !== 4'd1) begin
      $display("FAIL run_switch got trend=%b streak=%0d want 10/1", trend, streak); fails++;
    end
  endtask

  task automatic test_gap();
    do_clear();
    tests++;
    if ({eq_cnt, lt_cnt, gt_cnt, trend, streak} !== 18'd0) begin
      $display("FAIL clear_state got %h want 0", {eq_cnt, lt_cnt, gt_cnt, trend, streak}); fails++;
    end
    do_sample(3'b001);
    do_idle(5);
    tests++;
    if (trend !== 2'b01 || streak !== 4'd1 || eq_cnt !== 4'd1) begin
      $display("FAIL gap_hold got trend=%b streak=%0d eq=%0d want 01/1/1", trend, streak, eq_cnt);
      fails++;
    end
    do_sample(3'b001);
    tests++;
    if (trend !== 2'b01 || streak !== 4'd2 || eq_cnt !== 4'd2) begin
      $display("FAIL gap_run got trend=%b streak=%0d eq=%0d want 01/2/2", trend, streak, eq_cnt);
      fails++;
    end
  endtask

  task automatic test_illegal();
    logic [2:0] bad [3];
    bad[0] = 3'b011; bad[1] = 3'b000; bad[2] = 3'b111;
    for (int i = 0; i < 3; i++) begin
      do_sample(bad[i]);
      tests++;
      if (err !== 1'b1 || {eq_cnt, lt_cnt, gt_cnt} !== {4'd2, 4'd0, 4'd0} ||
          streak !== 4'd2 || trend !== 2'b01) begin
        $display("FAIL illegal_%b got err=%b eq=%0d lt=%0d gt=%0d streak=%0d trend=%b want 1/2/0/0/2/01",
                 bad[i], err, eq_cnt, lt_cnt, gt_cnt, streak, trend);
        fails++;
      end
    end
    do_sample(3'b001);
    tests++;
    if (err !== 1'b1 || eq_cnt !== 4'd3 || streak !== 4'd3) begin
      $display("FAIL illegal_then_legal got err=%b eq=%0d streak=%0d want 1/3/3", err, eq_cnt, streak);
      fails++;
    end
    do_idle(3);
    tests++;
    if (err !== 1'b1) begin
      $display("FAIL err_sticky got %b want 1", err); fails++;
    end
    do_clear();
    tests++;
    if (err !== 1'b0) begin
      $display("FAIL err_clear got %b want 0", err); fails++;
    end
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 0; i < 5; i++) do_sample(3'b001);
    tests++;
    if (s_eq_cnt !== 2'd3 || s_streak !== 2'd3 || s_trend !== 2'b01) begin
      $display("FAIL sat_small got eq=%0d streak=%0d trend=%b want 3/3/01", s_eq_cnt, s_streak, s_trend);
      fails++;
    end
    tests++;
    if (eq_cnt !== 4'd5 || streak !== 4'd5) begin
      $display("FAIL sat_wide got eq=%0d streak=%0d want 5/5", eq_cnt, streak); fails++;
    end
    do_sample(3'b100, 1'b1);
    tests++;
    if ({s_eq_cnt, s_lt_cnt, s_gt_cnt, s_trend, s_streak, s_err, s_alarm} !== 12'h000) begin
      $display("FAIL clr_with_valid_small got %h want 000",
               {s_eq_cnt, s_lt_cnt, s_gt_cnt, s_trend, s_streak, s_err, s_alarm}); fails++;
    end
    tests++;
    if (gt_cnt !== 4'd0 || eq_cnt !== 4'd0 || trend !== 2'b00 || streak !== 4'd0) begin
      $display("FAIL clr_with_valid got gt=%0d eq=%0d trend=%b streak=%0d want 0/0/00/0",
               gt_cnt, eq_cnt, trend, streak); fails++;
    end
  endtask

  task automatic test_alarm();
    logic [3:0] exp_al;
    // expected ALARM after LT #1, #2, #3, #4, then GT
    exp_al = ALARM_ON ? 4'b1100 : 4'b0000;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      do_sample(3'b010);
      tests++;
      if (alarm !== exp_al[i]) begin
        $display("FAIL alarm_lt%0d got %b want %b", i + 1, alarm, exp_al[i]); fails++;
      end
    end
    do_sample(3'b011);
    tests++;
    if (alarm !== exp_al[3]) begin
      $display("FAIL alarm_hold_illegal got %b want %b", alarm, exp_al[3]); fails++;
    end
    do_sample(3'b100);
    tests++;
    if (alarm !== 1'b0 || trend !== 2'b11 || streak !== 4'd1) begin
      $display("FAIL alarm_drop got alarm=%b trend=%b streak=%0d want 0/11/1", alarm, trend, streak);
      fails++;
    end
  endtask

  initial begin
    RST = 1'b0; CLR = 1'b0; VALID = 1'b0; F1 = 1'b0; F2 = 1'b0; F3 = 1'b0;
    test_reset();
    test_run_tracking();
    test_gap();
    test_illegal();
    test_saturation();
    test_alarm();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
